// File: rtl/uart_core.sv
// UART transceiver: parametrised baud, data width, parity and stop bits.
// TX serialises tx_data LSB first; RX oversamples a synchronised rx at mid-bit.
//
// TX state | meaning
// IDLE     | line high, tx_ready high, waiting for tx_valid
// START    | driving the start bit (low)
// DATA     | driving data bits, LSB first
// PAR      | driving the parity bit (only when PARITY != 0)
// STOP     | driving STOP_BITS stop bits (high)
//
// RX state | meaning
// IDLE     | waiting for a synchronised falling edge
// START    | waiting for mid start bit; a high sample is a false start
// DATA     | sampling data bits at mid-bit
// PAR      | sampling the parity bit
// STOP     | sampling the first stop bit, then reporting the word
// BREAK    | stop bit was low; waiting for the line to return high
module uart_core #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 57600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int              BIT_CLKS  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int              CNT_W     = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CLKS / 2 - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic            STOP_LAST = (STOP_BITS == 2);
  localparam bit              HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_t;

  tx_state_t            tx_state, tx_state_nxt;
  logic [CNT_W-1:0]     tx_cnt;
  logic [2:0]           tx_bit;
  logic                 tx_stop_idx;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par;
  logic                 tx_tc, tx_last_stop, tx_accept;

  assign tx_tc        = (tx_cnt == '0);
  assign tx_last_stop = (tx_state == TX_STOP) && tx_tc && (tx_stop_idx == STOP_LAST);
  assign tx_ready     = (tx_state == TX_IDLE) || tx_last_stop;
  assign tx_accept    = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_accept) tx_state_nxt = TX_START;
      TX_START: if (tx_tc) tx_state_nxt = TX_DATA;
      TX_DATA:
        if (tx_tc && tx_bit == DATA_LAST) begin
          if (HAS_PAR) tx_state_nxt = TX_PAR;
          else         tx_state_nxt = TX_STOP;
        end
      TX_PAR:   if (tx_tc) tx_state_nxt = TX_STOP;
      TX_STOP:
        if (tx_last_stop) begin
          if (tx_accept) tx_state_nxt = TX_START;
          else           tx_state_nxt = TX_IDLE;
        end
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  // tx is registered and updated on the same edge as the state change, so the pin never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_stop_idx <= 1'b0;
      tx_shreg    <= '0;
      tx_par      <= 1'b0;
      tx          <= 1'b1;
    end else if (tx_accept) begin
      tx_shreg <= tx_data;
      tx_par   <= (PARITY == 1) ? ~^tx_data : ^tx_data;
      tx_cnt   <= BIT_LAST;
      tx       <= 1'b0;
    end else if (tx_state != TX_IDLE) begin
      if (!tx_tc) begin
        tx_cnt <= tx_cnt - 1'b1;
      end else begin
        tx_cnt <= BIT_LAST;
        case (tx_state)
          TX_START: begin
            tx_bit <= '0;
            tx     <= tx_shreg[0];
          end
          TX_DATA: begin
            tx_shreg <= tx_shreg >> 1;
            tx_bit   <= tx_bit + 3'd1;
            if (tx_bit == DATA_LAST) begin
              tx_stop_idx <= 1'b0;
              tx          <= HAS_PAR ? tx_par : 1'b1;
            end else begin
              tx <= tx_shreg[1];
            end
          end
          TX_PAR: begin
            tx_stop_idx <= 1'b0;
            tx          <= 1'b1;
          end
          TX_STOP: begin
            tx_stop_idx <= 1'b1;
            tx          <= 1'b1;
          end
          default: tx <= 1'b1;
        endcase
      end
    end
  end

  rx_state_t            rx_state, rx_state_nxt;
  logic                 rx_meta, rx_sync, rx_prev, rx_fall;
  logic [CNT_W-1:0]     rx_cnt;
  logic [2:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_par_err;
  logic                 rx_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev && !rx_sync;
  assign rx_tc   = (rx_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_nxt = RX_START;
      RX_START:
        if (rx_tc) begin
          if (rx_sync) rx_state_nxt = RX_IDLE;
          else         rx_state_nxt = RX_DATA;
        end
      RX_DATA:
        if (rx_tc && rx_bit == DATA_LAST) begin
          if (HAS_PAR) rx_state_nxt = RX_PAR;
          else         rx_state_nxt = RX_STOP;
        end
      RX_PAR:   if (rx_tc) rx_state_nxt = RX_STOP;
      RX_STOP:
        if (rx_tc) begin
          if (rx_sync) rx_state_nxt = RX_IDLE;
          else         rx_state_nxt = RX_BREAK;
        end
      RX_BREAK: if (rx_sync) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shreg      <= '0;
      rx_par_err    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_fall) rx_cnt <= HALF_LAST;
        RX_START, RX_DATA, RX_PAR, RX_STOP: begin
          if (!rx_tc) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else begin
            rx_cnt <= BIT_LAST;
            case (rx_state)
              RX_START: rx_bit <= '0;
              RX_DATA: begin
                rx_shreg <= {rx_sync, rx_shreg[DATA_BITS-1:1]};
                rx_bit   <= rx_bit + 3'd1;
              end
              RX_PAR:
                rx_par_err <= (PARITY == 1) ? ~(^rx_shreg ^ rx_sync) : (^rx_shreg ^ rx_sync);
              RX_STOP: begin
                rx_data       <= rx_shreg;
                rx_parity_err <= rx_par_err;
                rx_frame_err  <= ~rx_sync;
                rx_valid      <= 1'b1;
              end
              default: rx_bit <= rx_bit;
            endcase
          end
        end
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

endmodule
